// File: rtl/qz_dec_pkg.sv
// qz_dec_pkg: shared widths and elaboration helpers for the VCO read-out
// CIC decimator (qz_cic_decimator and its comb stage).
package qz_dec_pkg;

    // Quantizer count width and nominal maximum count per clock.
    localparam int QZ_W   = 3;
    localparam int QZ_MAX = 5;

    // Accumulator/output width that holds QZ_MAX*r^2 without wrap.
    function automatic int cic_out_w(input int r);
        return 3 + 2 * $clog2(r);
    endfunction

    // DC gain of the sinc2 decimator applied to the idle count (offset*r^2).
    function automatic longint offset_gain(input int offset, input int r);
        return longint'(offset) * longint'(r) * longint'(r);
    endfunction

endpackage : qz_dec_pkg

// File: rtl/qz_cic_comb.sv
// qz_cic_comb: one registered CIC comb (difference) stage.
// On i_load the output register takes i_data minus the previously loaded
// value (minus a constant BIAS), and the delayed copy takes i_data.
// All arithmetic is modulo 2^W.
module qz_cic_comb #(
    parameter int           W    = 8,
    parameter logic [W-1:0] BIAS = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);

    logic [W-1:0] r_dly;
    logic [W-1:0] r_diff;

    // Difference register and delayed copy, both updated only on the load strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly  <= {W{1'b0}};
            r_diff <= {W{1'b0}};
        end else if (i_load) begin
            r_diff <= i_data - r_dly - BIAS;
            r_dly  <= i_data;
        end else begin
            r_dly  <= r_dly;
            r_diff <= r_diff;
        end
    end

    assign o_data = r_diff;

endmodule : qz_cic_comb

// File: rtl/qz_cic_decimator.sv
// qz_cic_decimator: 2nd-order CIC (sinc2) decimator by R for the VCO
// quantizer count stream, with a 1-deep valid/ready output register and a
// sticky overrun flag.
// Optional feature macro: QZ_DEC_OFFSET_EN -- subtracts OFFSET*R^2 so the
// idle VCO count maps to 0 and out_data reads as two's complement.
module qz_cic_decimator
    import qz_dec_pkg::*;
#(
    parameter int R      = 16,
    parameter int OUT_W  = cic_out_w(R),
    parameter int OFFSET = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [QZ_W-1:0]  in_qz,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovr
);

    localparam int               CNT_W    = (R > 1) ? $clog2(R) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(R - 1);

`ifdef QZ_DEC_OFFSET_EN
    localparam bit OFFSET_EN = 1'b1;
`else
    localparam bit OFFSET_EN = 1'b0;
`endif

    // Constant removed in the final comb so the idle count decodes to zero.
    localparam logic [OUT_W-1:0] OUT_BIAS =
        OFFSET_EN ? OUT_W'(offset_gain(OFFSET, R)) : {OUT_W{1'b0}};

    logic [OUT_W-1:0] r_int1;
    logic [OUT_W-1:0] r_int2;
    logic [CNT_W-1:0] r_dec_cnt;
    logic             r_pend;
    logic             r_out_valid;
    logic             r_ovr;
    logic             w_dec;
    logic [OUT_W-1:0] w_c1;
    logic [OUT_W-1:0] w_out;

    // Decimation edge: last enabled clock of each group of R.
    assign w_dec = en && (r_dec_cnt == CNT_LAST);

    // Two cascaded integrators; int2 accumulates the pre-update int1, wrap intended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int1 <= {OUT_W{1'b0}};
            r_int2 <= {OUT_W{1'b0}};
        end else if (en) begin
            r_int1 <= r_int1 + {{(OUT_W - QZ_W){1'b0}}, in_qz};
            r_int2 <= r_int2 + r_int1;
        end else begin
            r_int1 <= r_int1;
            r_int2 <= r_int2;
        end
    end

    // Decimation counter 0..R-1, advancing only on enabled clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dec_cnt <= {CNT_W{1'b0}};
        end else if (w_dec) begin
            r_dec_cnt <= {CNT_W{1'b0}};
        end else if (en) begin
            r_dec_cnt <= r_dec_cnt + {{(CNT_W - 1){1'b0}}, 1'b1};
        end else begin
            r_dec_cnt <= r_dec_cnt;
        end
    end

    // Pending strobe: the second comb fires one clock after each decimation edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 1'b0;
        end else begin
            r_pend <= w_dec;
        end
    end

    // First comb: c1 = int2 - int2_d on the decimation edge.
    qz_cic_comb #(
        .W    (OUT_W),
        .BIAS ({OUT_W{1'b0}})
    ) u_comb1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_dec),
        .i_data (r_int2),
        .o_data (w_c1)
    );

    // Second comb: its register is the output sample register.
    qz_cic_comb #(
        .W    (OUT_W),
        .BIAS (OUT_BIAS)
    ) u_comb2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (r_pend),
        .i_data (w_c1),
        .o_data (w_out)
    );

    // Output handshake: new samples set valid, a stalled overwrite sets sticky ovr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_ovr       <= 1'b0;
        end else if (r_pend) begin
            r_out_valid <= 1'b1;
            if (r_out_valid && !out_ready) begin
                r_ovr <= 1'b1;
            end else begin
                r_ovr <= r_ovr;
            end
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_ovr       <= r_ovr;
        end else begin
            r_out_valid <= r_out_valid;
            r_ovr       <= r_ovr;
        end
    end

    assign out_data  = w_out;
    assign out_valid = r_out_valid;
    assign ovr       = r_ovr;

endmodule : qz_cic_decimator

// File: tb/tb_qz_cic_decimator.sv
// tb_qz_cic_decimator: self-checking bench for qz_cic_decimator at R=4, 16
// and 256, with a sinc2 reference model computed directly from the input
// history (weighted sums of accepted samples).
module tb_qz_cic_decimator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  in_qz = 3'd0;

    logic [6:0]  d4;
    logic        v4, o4;
    logic [10:0] d16;
    logic        v16, o16;
    logic [18:0] d256;
    logic        v256, o256;

    int n_checks = 0;
    int n_fail   = 0;
    int xs[$];

`ifdef QZ_DEC_OFFSET_EN
    localparam longint OFF4 = 48;
`else
    localparam longint OFF4 = 0;
`endif

    always #5 clk = ~clk;

    qz_cic_decimator #(.R(4), .OFFSET(3)) u4 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_qz(in_qz),
        .out_data(d4), .out_valid(v4), .out_ready(out_ready), .ovr(o4));

    qz_cic_decimator #(.R(16)) u16 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_qz(in_qz),
        .out_data(d16), .out_valid(v16), .out_ready(out_ready), .ovr(o16));

    qz_cic_decimator #(.R(256)) u256 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_qz(in_qz),
        .out_data(d256), .out_valid(v256), .out_ready(out_ready), .ovr(o256));

    // Sum of the second integrator seen at decimation k: sum (kR-1-i)*x_i.
    function automatic longint model_v(input int k, input int r);
        longint s;
        s = 0;
        if (k <= 0) return 0;
        for (int i = 1; i <= k * r - 2; i++)
            s += longint'(k * r - 1 - i) * longint'(xs[i-1]);
        return s;
    endfunction

    // k-th decimated output = second difference of model_v, minus bias, mod 2^w.
    function automatic longint model_out(input int k, input int r, input longint bias, input int w);
        longint d;
        d = model_v(k, r) - 2 * model_v(k - 1, r) + model_v(k - 2, r) - bias;
        return d & ((longint'(1) << w) - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; in_qz = 3'd0; out_ready = 1'b0;
        xs.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (v4 !== 1'b0)      begin n_fail++; $display("FAIL reset_v4: got %0b expected 0", v4); end
        n_checks++; if (o4 !== 1'b0)      begin n_fail++; $display("FAIL reset_o4: got %0b expected 0", o4); end
        n_checks++; if (d4 !== 7'd0)      begin n_fail++; $display("FAIL reset_d4: got %0d expected 0", d4); end
        n_checks++; if (v16 !== 1'b0)     begin n_fail++; $display("FAIL reset_v16: got %0b expected 0", v16); end
        n_checks++; if (o16 !== 1'b0)     begin n_fail++; $display("FAIL reset_o16: got %0b expected 0", o16); end
        n_checks++; if (d16 !== 11'd0)    begin n_fail++; $display("FAIL reset_d16: got %0d expected 0", d16); end
        n_checks++; if (v256 !== 1'b0)    begin n_fail++; $display("FAIL reset_v256: got %0b expected 0", v256); end
        n_checks++; if (d256 !== 19'd0)   begin n_fail++; $display("FAIL reset_d256: got %0d expected 0", d256); end
    endtask

    task automatic test_dc_r4();
        int nsamp;
        int last;
        logic [6:0] e;
        nsamp = 0; last = -1;
        e = 7'((48 - OFF4) & 127);
        do_reset();
        en = 1'b1; in_qz = 3'd3; out_ready = 1'b1;
        for (int c = 1; c <= 44; c++) begin
            tick();
            if (v4) begin
                nsamp++;
                if (nsamp >= 2) begin
                    n_checks++;
                    if (c - last != 4) begin n_fail++; $display("FAIL dc_r4_spacing: got %0d expected 4", c - last); end
                end
                if (nsamp >= 3) begin
                    n_checks++;
                    if (d4 !== e) begin n_fail++; $display("FAIL dc_r4_data: got %0d expected %0d", d4, e); end
                end
                last = c;
            end
        end
        n_checks++; if (nsamp != 10) begin n_fail++; $display("FAIL dc_r4_count: got %0d expected 10", nsamp); end
        n_checks++; if (o4 !== 1'b0) begin n_fail++; $display("FAIL dc_r4_ovr: got %0b expected 0", o4); end
    endtask

    task automatic test_dc_r16_max();
        int nsamp;
        int last;
        nsamp = 0; last = -1;
        do_reset();
        en = 1'b1; in_qz = 3'd5; out_ready = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (v16) begin
                nsamp++;
                if (nsamp >= 2) begin
                    n_checks++;
                    if (c - last != 16) begin n_fail++; $display("FAIL dc_r16_spacing: got %0d expected 16", c - last); end
                end
                if (nsamp >= 3) begin
                    n_checks++;
                    if (d16 !== 11'd1280) begin n_fail++; $display("FAIL dc_r16_data: got %0d expected 1280", d16); end
                end
                last = c;
            end
        end
        n_checks++; if (nsamp != 12) begin n_fail++; $display("FAIL dc_r16_count: got %0d expected 12", nsamp); end
    endtask

    task automatic test_en_toggle();
        int nsamp;
        int last;
        logic [6:0] e;
        nsamp = 0; last = -1;
        e = 7'((32 - OFF4) & 127);
        do_reset();
        in_qz = 3'd2; out_ready = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            en = (c % 2 == 1);
            tick();
            if (v4) begin
                nsamp++;
                if (nsamp >= 2) begin
                    n_checks++;
                    if (c - last != 8) begin n_fail++; $display("FAIL en_toggle_spacing: got %0d expected 8", c - last); end
                end
                if (nsamp >= 3) begin
                    n_checks++;
                    if (d4 !== e) begin n_fail++; $display("FAIL en_toggle_data: got %0d expected %0d", d4, e); end
                end
                last = c;
            end
        end
        n_checks++; if (nsamp != 10) begin n_fail++; $display("FAIL en_toggle_count: got %0d expected 10", nsamp); end
    endtask

    task automatic test_overrun();
        logic [6:0] e1;
        logic [6:0] e2;
        do_reset();
        repeat (20) xs.push_back(1);
        e1 = 7'(model_out(1, 4, OFF4, 7));
        e2 = 7'(model_out(2, 4, OFF4, 7));
        en = 1'b1; in_qz = 3'd1; out_ready = 1'b0;
        repeat (4) tick();
        n_checks++; if (v4 !== 1'b0) begin n_fail++; $display("FAIL ovr_pre_valid: got %0b expected 0", v4); end
        tick();
        n_checks++; if (v4 !== 1'b1) begin n_fail++; $display("FAIL ovr_first_valid: got %0b expected 1", v4); end
        n_checks++; if (d4 !== e1)   begin n_fail++; $display("FAIL ovr_first_data: got %0d expected %0d", d4, e1); end
        n_checks++; if (o4 !== 1'b0) begin n_fail++; $display("FAIL ovr_first_flag: got %0b expected 0", o4); end
        repeat (4) tick();
        n_checks++; if (v4 !== 1'b1) begin n_fail++; $display("FAIL ovr_second_valid: got %0b expected 1", v4); end
        n_checks++; if (d4 !== e2)   begin n_fail++; $display("FAIL ovr_second_data: got %0d expected %0d", d4, e2); end
        n_checks++; if (o4 !== 1'b1) begin n_fail++; $display("FAIL ovr_second_flag: got %0b expected 1", o4); end
        en = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++; if (v4 !== 1'b0) begin n_fail++; $display("FAIL ovr_consume_valid: got %0b expected 0", v4); end
        n_checks++; if (o4 !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %0b expected 1", o4); end
    endtask

    task automatic test_wrap_r256();
        int nsamp;
        nsamp = 0;
        do_reset();
        en = 1'b1; in_qz = 3'd5; out_ready = 1'b1;
        for (int c = 1; c <= 10000; c++) begin
            tick();
            if (v256) begin
                nsamp++;
                if (nsamp >= 3) begin
                    n_checks++;
                    if (d256 !== 19'd327680) begin n_fail++; $display("FAIL wrap_r256_data: sample %0d got %0d expected 327680", nsamp, d256); end
                end
            end
        end
        n_checks++; if (nsamp != 39) begin n_fail++; $display("FAIL wrap_r256_count: got %0d expected 39", nsamp); end
        n_checks++; if (o256 !== 1'b0) begin n_fail++; $display("FAIL wrap_r256_ovr: got %0b expected 0", o256); end
    endtask

    task automatic test_random_model();
        int  n;
        int  k;
        bit  exp_next;
        logic [10:0] e;
        n = 0; k = 0; exp_next = 1'b0;
        do_reset();
        out_ready = 1'b1;
        for (int c = 1; c <= 800; c++) begin
            en    = ($urandom_range(0, 3) != 0);
            in_qz = 3'($urandom_range(0, 7));
            tick();
            if (en) begin
                xs.push_back(int'(in_qz));
                n++;
            end
            n_checks++;
            if (v16 !== exp_next) begin n_fail++; $display("FAIL rand_valid: cycle %0d got %0b expected %0b", c, v16, exp_next); end
            if (exp_next) begin
                k++;
                e = 11'(model_out(k, 16, 0, 11));
                n_checks++;
                if (d16 !== e) begin n_fail++; $display("FAIL rand_data: sample %0d got %0d expected %0d", k, d16, e); end
            end
            exp_next = en && (n % 16 == 0);
        end
        n_checks++; if (o16 !== 1'b0) begin n_fail++; $display("FAIL rand_ovr: got %0b expected 0", o16); end
    endtask

    task automatic test_async_reset();
        int first;
        int nsamp;
        logic [6:0] e;
        first = -1; nsamp = 0;
        e = 7'((48 - OFF4) & 127);
        do_reset();
        en = 1'b1; in_qz = 3'd3; out_ready = 1'b0;
        repeat (10) tick();
        n_checks++; if (o4 !== 1'b1) begin n_fail++; $display("FAIL arst_setup_ovr: got %0b expected 1", o4); end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (v4 !== 1'b0)  begin n_fail++; $display("FAIL arst_valid: got %0b expected 0", v4); end
        n_checks++; if (d4 !== 7'd0)  begin n_fail++; $display("FAIL arst_data: got %0d expected 0", d4); end
        n_checks++; if (o4 !== 1'b0)  begin n_fail++; $display("FAIL arst_ovr: got %0b expected 0", o4); end
        n_checks++; if (d16 !== 11'd0) begin n_fail++; $display("FAIL arst_data16: got %0d expected 0", d16); end
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1; in_qz = 3'd3; out_ready = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (v4) begin
                nsamp++;
                if (first < 0) first = c;
                if (nsamp == 3) begin
                    n_checks++;
                    if (d4 !== e) begin n_fail++; $display("FAIL arst_steady: got %0d expected %0d", d4, e); end
                end
            end
        end
        // Decimation edge is the 4th enabled edge; the sample lands on the next one.
        n_checks++; if (first != 5) begin n_fail++; $display("FAIL arst_first_valid: edge %0d expected 5", first); end
    endtask

    initial begin
        test_reset();
        test_dc_r4();
        test_dc_r16_max();
        test_en_toggle();
        test_overrun();
        test_wrap_r256();
        test_random_model();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_qz_cic_decimator
